multicast_dispatcher: RTL and testbench

MULTICAST_DISPATCHER -- requirements
Module: multicast_dispatcher

---
 rtl/multicast_dispatcher.sv | 180 ++++++++++++++++++
 tb/tb_multicast_dispatcher.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicast_dispatcher.sv
// Multicast dispatcher: queues bus words and delivers each one to a set of PE
// columns selected by tag match, broadcast or an explicit mask. A word stays
// presented on out_data until every targeted column has accepted it. A word
// that selects no column is discarded with a one-cycle drop pulse.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   in_valid/in_ready input handshake; in_data, in_tag, in_mode, in_mask payload
//   col_id            per-column IDs, column i at [i*TAG_W +: TAG_W]
//   out_data          payload shared by all columns
//   pe_valid/pe_ready per-column delivery handshake
//   drop              pulse when a word targets no column
//   fifo_count, busy  queue occupancy and activity status
module multicast_dispatcher #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_COL    = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned TAG_W     = $clog2(NUM_COL),
    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    in_data,
    input  logic [TAG_W-1:0]         in_tag,
    input  logic [1:0]               in_mode,
    input  logic [NUM_COL-1:0]       in_mask,
    input  logic [NUM_COL*TAG_W-1:0] col_id,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic [NUM_COL-1:0]       pe_valid,
    input  logic [NUM_COL-1:0]       pe_ready,
    output logic                     drop,
    output logic [CNT_W-1:0]         fifo_count,
    output logic                     busy
);

    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned ENTRY_W = 2 + TAG_W + NUM_COL + DATA_WIDTH;

    localparam logic [1:0] MODE_TAG   = 2'b00;
    localparam logic [1:0] MODE_BCAST = 2'b01;
    localparam logic [1:0] MODE_MASK  = 2'b10;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                 state;
    state_t                 state_nx;
    logic [NUM_COL-1:0]     pending_nx;
    logic [DATA_WIDTH-1:0]  data_nx;
    logic                   drop_nx;
    logic                   load;
    logic [NUM_COL-1:0]     remaining;

    logic [ENTRY_W-1:0]     mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic                   push;
    logic                   pop;
    logic                   not_empty;

    logic [ENTRY_W-1:0]     head;
    logic [DATA_WIDTH-1:0]  head_data;
    logic [NUM_COL-1:0]     head_mask;
    logic [TAG_W-1:0]       head_tag;
    logic [1:0]             head_mode;
    logic [NUM_COL-1:0]     target;

    // Ready depends only on the registered count, never on a same-cycle pop.
    assign in_ready  = (fifo_count != CNT_W'(FIFO_DEPTH));
    assign not_empty = (fifo_count != '0);
    assign push      = in_valid && in_ready && !rst;
    assign busy      = (state == SEND) || not_empty;

    // Queue entry layout: {mode, tag, mask, data}.
    assign head      = mem[rd_ptr];
    assign head_data = head[DATA_WIDTH-1:0];
    assign head_mask = head[DATA_WIDTH +: NUM_COL];
    assign head_tag  = head[DATA_WIDTH+NUM_COL +: TAG_W];
    assign head_mode = head[ENTRY_W-1 -: 2];

    // Queue storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_mode, in_tag, in_mask, in_data};
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Target column set of the head word.
    always_comb begin
        target = '0;
        case (head_mode)
            MODE_TAG: begin
                for (int i = 0; i < NUM_COL; i++) begin
                    target[i] = (col_id[i*TAG_W +: TAG_W] == head_tag);
                end
            end
            MODE_BCAST: target = '1;
            MODE_MASK:  target = head_mask;
            default:    target = '0;
        endcase
    end

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pe_valid <= '0;
            out_data <= '0;
            drop     <= 1'b0;
        end else begin
            state    <= state_nx;
            pe_valid <= pending_nx;
            out_data <= data_nx;
            drop     <= drop_nx;
        end
    end

    // Next-state logic; pe_valid doubles as the pending-column register.
    always_comb begin
        state_nx   = state;
        pending_nx = pe_valid;
        data_nx    = out_data;
        drop_nx    = 1'b0;
        load       = 1'b0;
        pop        = 1'b0;
        remaining  = pe_valid & ~pe_ready;

        case (state)
            IDLE: begin
                load = not_empty;
            end
            SEND: begin
                if (remaining != '0) begin
                    pending_nx = remaining;
                end else if (not_empty) begin
                    // Back-to-back load with no bubble.
                    load = 1'b1;
                end else begin
                    state_nx   = IDLE;
                    pending_nx = '0;
                end
            end
        endcase

        if (load) begin
            pop     = 1'b1;
            data_nx = head_data;
            if (target != '0) begin
                state_nx   = SEND;
                pending_nx = target;
            end else begin
                state_nx   = IDLE;
                pending_nx = '0;
                drop_nx    = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multicast_dispatcher.sv
// Bench for multicast_dispatcher: transaction-level queue model, a per-cycle
// compare process, directed scenarios with literal expectations, then random
// traffic with occasional resets and column-ID changes.
module tb_multicast_dispatcher;

    localparam int unsigned DW = 16;
    localparam int unsigned NC = 4;
    localparam int unsigned FD = 4;
    localparam int unsigned TW = 2;
    localparam int unsigned CW = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic [TW-1:0]   in_tag;
    logic [1:0]      in_mode;
    logic [NC-1:0]   in_mask;
    logic [NC*TW-1:0] col_id;
    logic [DW-1:0]   out_data;
    logic [NC-1:0]   pe_valid;
    logic [NC-1:0]   pe_ready;
    logic            drop;
    logic [CW-1:0]   fifo_count;
    logic            busy;

    multicast_dispatcher #(
        .DATA_WIDTH(DW),
        .NUM_COL   (NC),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .in_mode   (in_mode),
        .in_mask   (in_mask),
        .col_id    (col_id),
        .out_data  (out_data),
        .pe_valid  (pe_valid),
        .pe_ready  (pe_ready),
        .drop      (drop),
        .fifo_count(fifo_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model: a queue of words plus the word currently on offer.
    typedef struct {
        logic [1:0]    mode;
        logic [TW-1:0] tag;
        logic [NC-1:0] mask;
        logic [DW-1:0] data;
    } word_t;

    word_t         m_q[$];
    logic [NC-1:0] m_pend = '0;
    logic [DW-1:0] m_data = '0;
    bit            m_drop = 1'b0;
    bit            m_accepted = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NC-1:0] target_of(input word_t w, input logic [NC*TW-1:0] ids);
        logic [NC-1:0] t = '0;
        case (w.mode)
            2'd0: for (int i = 0; i < NC; i++) t[i] = (ids[i*TW +: TW] == w.tag);
            2'd1: t = '1;
            2'd2: t = w.mask;
            default: t = '0;
        endcase
        return t;
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_update();
        word_t         w;
        logic [NC-1:0] rem;
        logic [NC-1:0] t;
        bit            load;
        bit            rdy;
        m_accepted = 1'b0;
        if (rst) begin
            m_q.delete();
            m_pend = '0;
            m_data = '0;
            m_drop = 1'b0;
            return;
        end
        rdy  = (m_q.size() != FD);
        load = 1'b0;
        m_drop = 1'b0;
        if (m_pend == '0) begin
            load = (m_q.size() != 0);
        end else begin
            rem = m_pend & ~pe_ready;
            if (rem != '0) m_pend = rem;
            else if (m_q.size() != 0) load = 1'b1;
            else m_pend = '0;
        end
        if (load) begin
            w      = m_q.pop_front();
            m_data = w.data;
            t      = target_of(w, col_id);
            m_pend = t;
            m_drop = (t == '0);
        end
        if (in_valid && rdy) begin
            w.mode = in_mode;
            w.tag  = in_tag;
            w.mask = in_mask;
            w.data = in_data;
            m_q.push_back(w);
            m_accepted = 1'b1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_update();
    endtask

    task automatic push(input logic [1:0] mode, input logic [TW-1:0] tag,
                        input logic [NC-1:0] mask, input logic [DW-1:0] data);
        in_valid = 1'b1;
        in_mode  = mode;
        in_tag   = tag;
        in_mask  = mask;
        in_data  = data;
        step();
        in_valid = 1'b0;
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready",   32'(in_ready),   32'(m_q.size() != FD));
            chk("fifo_count", 32'(fifo_count), 32'(m_q.size()));
            chk("pe_valid",   32'(pe_valid),   32'(m_pend));
            chk("out_data",   32'(out_data),   32'(m_data));
            chk("drop",       32'(drop),       32'(m_drop));
            chk("busy",       32'(busy),       32'((m_pend != '0) || (m_q.size() != 0)));
        end
    end

    initial begin
        int idx;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_tag   = '0;
        in_mode  = '0;
        in_mask  = '0;
        col_id   = 8'hE4;
        pe_ready = 4'hF;
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_pe_valid", 32'(pe_valid), 32'd0);
        step();

        // TAG delivery to column 2, latency two cycles.
        push(2'd0, 2'd2, 4'h0, 16'hABCD);
        chk("tag_c1_pe_valid", 32'(pe_valid), 32'd0);
        step();
        chk("tag_c2_pe_valid", 32'(pe_valid), 32'h4);
        chk("tag_c2_out_data", 32'(out_data), 32'hABCD);
        step();
        chk("tag_c3_pe_valid", 32'(pe_valid), 32'd0);
        chk("tag_c3_busy",     32'(busy),     32'd0);

        // Staggered broadcast acceptance.
        pe_ready = 4'h0;
        push(2'd1, 2'd0, 4'h0, 16'h1234);
        step();
        chk("bc_pv0", 32'(pe_valid), 32'hF);
        chk("bc_od0", 32'(out_data), 32'h1234);
        pe_ready = 4'h1; step();
        chk("bc_pv1", 32'(pe_valid), 32'hE);
        pe_ready = 4'h6; step();
        chk("bc_pv2", 32'(pe_valid), 32'h8);
        chk("bc_od2", 32'(out_data), 32'h1234);
        pe_ready = 4'h8; step();
        chk("bc_pv3", 32'(pe_valid), 32'h0);

        // Tag that matches no column is dropped.
        col_id = 8'h00;
        push(2'd0, 2'd3, 4'h0, 16'h0BAD);
        step();
        chk("drop_pulse",  32'(drop),       32'd1);
        chk("drop_pv",     32'(pe_valid),   32'd0);
        chk("drop_count",  32'(fifo_count), 32'd0);
        step();
        chk("drop_end",    32'(drop),       32'd0);
        col_id = 8'hE4;

        // Full queue under backpressure, then drain with no bubble.
        pe_ready = 4'h0;
        idx = 0;
        in_valid = 1'b1;
        in_mode  = 2'd1;
        for (int c = 0; c < 8; c++) begin
            in_data = 16'h0100 + 16'(idx);
            step();
            if (m_accepted) idx++;
        end
        in_valid = 1'b0;
        chk("full_accepted", 32'(idx),        32'd5);
        chk("full_count",    32'(fifo_count), 32'd4);
        chk("full_ready",    32'(in_ready),   32'd0);
        chk("full_od",       32'(out_data),   32'h0100);
        pe_ready = 4'hF;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("drain_pv", 32'(pe_valid), 32'hF);
            chk("drain_od", 32'(out_data), 32'h0100 + 32'(k));
        end
        step();
        chk("drain_end_pv",   32'(pe_valid), 32'd0);
        chk("drain_end_busy", 32'(busy),     32'd0);

        // Mask delivery followed by a reserved-mode word.
        push(2'd2, 2'd0, 4'hA, 16'h00AA);
        push(2'd3, 2'd0, 4'hF, 16'h0055);
        chk("mask_pv", 32'(pe_valid), 32'hA);
        chk("mask_od", 32'(out_data), 32'h00AA);
        step();
        chk("rsv_drop", 32'(drop),     32'd1);
        chk("rsv_pv",   32'(pe_valid), 32'd0);
        step();
        chk("rsv_drop_end", 32'(drop), 32'd0);

        // Reset while sending with two words queued; in_valid during reset is ignored.
        pe_ready = 4'h0;
        push(2'd1, 2'd0, 4'h0, 16'h0A0A);
        push(2'd1, 2'd0, 4'h0, 16'h0B0B);
        push(2'd1, 2'd0, 4'h0, 16'h0C0C);
        chk("pre_rst_pv",    32'(pe_valid),   32'hF);
        chk("pre_rst_count", 32'(fifo_count), 32'd2);
        rst = 1'b1;
        in_valid = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("post_rst_pv",    32'(pe_valid),   32'd0);
        chk("post_rst_count", 32'(fifo_count), 32'd0);
        chk("post_rst_ready", 32'(in_ready),   32'd1);
        chk("post_rst_busy",  32'(busy),       32'd0);
        chk("post_rst_od",    32'(out_data),   32'd0);

        // Random traffic.
        for (int c = 0; c < 4000; c++) begin
            rst      = ($urandom_range(0, 299) == 0);
            in_valid = ($urandom_range(0, 9) < 6);
            in_mode  = 2'($urandom_range(0, 3));
            in_tag   = 2'($urandom);
            in_mask  = 4'($urandom);
            in_data  = 16'($urandom);
            pe_ready = 4'($urandom);
            if ($urandom_range(0, 99) == 0) col_id = 8'($urandom);
            step();
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        pe_ready = 4'hF;
        for (int c = 0; c < 10; c++) step();
        chk("final_busy", 32'(busy), 32'd0);

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
